// File: rtl/regfile_pkg.sv
// Shared sizes, constants and typedefs for the register file with hazard scoreboard.
package regfile_pkg;
  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]      reg_data_t;
endpackage

// File: rtl/pending_popcount.sv
// Combinational population count of the scoreboard pending bitmap.
module pending_popcount #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 6
) (
  input  logic [N-1:0]  i_vec,
  output logic [CW-1:0] o_count_c
);

  always_comb begin
    o_count_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_count_c = o_count_c + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file (r0 hard-wired to zero) with a pending-producer scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH      = REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [ADDR_WIDTH-1:0]   ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]   ReadRegister2,
  output logic [WIDTH-1:0]        ReadData1,
  output logic [WIDTH-1:0]        ReadData2,
  output logic                    ReadBusy1,
  output logic                    ReadBusy2,
  input  logic [ADDR_WIDTH-1:0]   WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic                    RegWrite,
  input  logic [ADDR_WIDTH-1:0]   ReserveRegister,
  input  logic                    Reserve,
  output logic [2**ADDR_WIDTH-1:0] Pending,
  output logic [ADDR_WIDTH:0]     PendingCount
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;
  logic [CNT_W-1:0] r_pending_count;
  logic [CNT_W-1:0] w_pending_count;
  logic             w_wr_en;
  logic             w_rsv_en;

  assign w_wr_en  = RegWrite && (WriteRegister != ADDR_WIDTH'(REG_ZERO));
  assign w_rsv_en = Reserve && (ReserveRegister != ADDR_WIDTH'(REG_ZERO));

  // Reserve is applied after the write clear so a new producer wins on the same edge.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_en)  w_pending_nxt[WriteRegister]   = 1'b0;
    if (w_rsv_en) w_pending_nxt[ReserveRegister] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  pending_popcount #(
    .N  (DEPTH),
    .CW (CNT_W)
  ) u_popcount (
    .i_vec     (w_pending_nxt),
    .o_count_c (w_pending_count)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pending       <= '0;
      r_pending_count <= '0;
    end else begin
      r_pending       <= w_pending_nxt;
      r_pending_count <= w_pending_count;
    end
  end

  assign Pending      = r_pending;
  assign PendingCount = r_pending_count;

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Reset gating keeps the read ports at zero while reset is asserted.
  assign w_byp1 = Rst_n && w_wr_en && (WriteRegister == ReadRegister1);
  assign w_byp2 = Rst_n && w_wr_en && (WriteRegister == ReadRegister2);

  assign ReadData1 = w_byp1 ? WriteData : r_regs[ReadRegister1];
  assign ReadData2 = w_byp2 ? WriteData : r_regs[ReadRegister2];
  assign ReadBusy1 = r_pending[ReadRegister1] && !w_byp1;
  assign ReadBusy2 = r_pending[ReadRegister2] && !w_byp2;
`else
  assign ReadData1 = r_regs[ReadRegister1];
  assign ReadData2 = r_regs[ReadRegister2];
  assign ReadBusy1 = r_pending[ReadRegister1];
  assign ReadBusy2 = r_pending[ReadRegister2];
`endif

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register file with hazard scoreboard: the storage and responder side of the CPU register interface that the core and its regfile benches drive. It holds 32 general-purpose registers with a hard-wired zero register, two combinational read ports and one clocked write port. It also tracks which registers have an in-flight producer, such as a multi-cycle load, so that issue logic can stall on the busy flags. Optional write-through bypass lets a register be read in the same cycle it is written.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register.
- `ADDR_WIDTH`, 5, register address width; depth is 2**ADDR_WIDTH.

Ports:
- `Clk`  in  1  clock, positive-edge triggered.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `ReadRegister1`  in  ADDR_WIDTH  read port 1 address.
- `ReadRegister2`  in  ADDR_WIDTH  read port 2 address.
- `ReadData1`  out  WIDTH  read port 1 data.
- `ReadData2`  out  WIDTH  read port 2 data.
- `ReadBusy1`  out  1  register addressed on port 1 has a pending producer.
- `ReadBusy2`  out  1  register addressed on port 2 has a pending producer.
- `WriteRegister`  in  ADDR_WIDTH  write address.
- `WriteData`  in  WIDTH  write data.
- `RegWrite`  in  1  write enable.
- `ReserveRegister`  in  ADDR_WIDTH  destination being issued.
- `Reserve`  in  1  mark `ReserveRegister` pending.
- `Pending`  out  2**ADDR_WIDTH  scoreboard bitmap; bit 0 is always 0.
- `PendingCount`  out  ADDR_WIDTH+1  number of set bits in `Pending`.

## Operation
- Register 0:
  - Reads return 0.
  - Writes to it are ignored.
  - Reserving it is ignored.
  - Its busy flag is always 0.
- Write: at posedge `Clk` with `RegWrite`=1 and `WriteRegister`≠0:
  - `reg[WriteRegister]` ← `WriteData`.
  - `Pending[WriteRegister]` ← 0.
- A write to a register that is not pending is legal (ordinary ALU writeback); the scoreboard is unchanged.
- Reserve: at posedge `Clk` with `Reserve`=1 and `ReserveRegister`≠0, `Pending[ReserveRegister]` ← 1.
- Reserving a register that is already pending leaves it set; the count does not change.
- Reserve and write to the same register on the same edge: data is written and `Pending` stays 1, because the new producer wins.
- Reserve and write to different registers on the same edge: both take effect.
- Reads are combinational:
  - `ReadDataN` = `reg[ReadRegisterN]`.
  - `ReadBusyN` = `Pending[ReadRegisterN]`.
- `PendingCount` is registered. It is computed from the next value of `Pending`, so it always equals the popcount of `Pending` (range 0..31).

## Timing
- Reset (`Rst_n`=0) acts immediately, independent of `Clk`:
  - All registers, `Pending` and `PendingCount` go to 0.
  - `ReadData1/2` and `ReadBusy1/2` go to 0.
- Reset asserted mid-operation discards all in-flight reservations and data. The first edge after deassertion behaves as from cold.
- Write latency without bypass: the value appears on the read ports in the cycle after the write edge.
- Reserve latency: `ReadBusyN` and `Pending` change in the cycle after the reserve edge.
- Write clears busy in the cycle after the edge (same cycle with bypass, see Configuration).

## Configuration
- `REGFILE_BYPASS_EN` defined: when `RegWrite`=1, `WriteRegister`≠0 and `WriteRegister`==`ReadRegisterN`:
  - `ReadDataN` = `WriteData`, combinationally.
  - `ReadBusyN` = 0 in that cycle.
- `REGFILE_BYPASS_EN` undefined: read ports see only stored state. There is no combinational path from the write port to the read ports.

## Structure
- Package `regfile_pkg` holds:
  - `REG_WIDTH` = 32 and `REG_ADDR_WIDTH` = 5.
  - `REG_ZERO` = 5'd0.
  - Typedefs `reg_addr_t` and `reg_data_t`.
- One sub-module, `pending_popcount`: combinational popcount of a 32-bit vector. It feeds the `PendingCount` register.

## Test plan
- Reset, then release:
  - Read registers 0, 5 and 31 on both ports → data 0, busy 0, `PendingCount`=0.
- Write 42 to register 2, then 15 to register 2:
  - Each value appears on both ports the next cycle.
  - `RegWrite`=0 with `WriteData`=20 → reads stay 15.
- Write 15 to register 0 and reserve register 0:
  - Reads of register 0 return 0, busy 0.
  - `Pending`=0, `PendingCount`=0.
- Reserve registers 3 and 7 on consecutive edges:
  - `ReadBusy` set for both; `PendingCount`=2.
  - Write 99 to register 3 → busy3=0, data 99, `PendingCount`=1.
  - Reserve and write register 7 on the same edge → busy7 stays 1, data updated, count 1.
- Reserve registers 3 and 7, then pulse `Rst_n` low between clock edges:
  - `Pending`, `PendingCount` and all data read 0 immediately.
- Bypass, with `REGFILE_BYPASS_EN` defined:
  - Reserve register 4, then `RegWrite` register 4 = 0xDEADBEEF while reading register 4 → same-cycle `ReadData1`=0xDEADBEEF, busy 0.
  - With the macro undefined, the same stimulus gives the old data and busy 1 until the edge.
